scr_stack_ctrl: RTL and testbench
=================================

// Module: scr_stack_ctrl
// PURPOSE
//  Sequences the scratch RAM (SCR) for stack operations: PUSH/POP of an 8-bit register and CALL/RET of the 10-bit PC.
//  Owns the stack pointer (SP) and stack occupancy. Drives SCR address, write enable and the SCR data-mux select
//  (0 = zero-extended register, 1 = PC). Sits between the control unit (op handshake) and the SCR/data-mux datapath.
// PARAMETERS
//  ADDR_W    8      SCR address width; stack holds 2**ADDR_W entries
//  DATA_W    10     SCR word width (PC width)
//  REG_W     8      register width; pushed as {(DATA_W-REG_W)'b0, reg}
//  SP_RESET  8'h00  SP value after reset
// PORTS
//  CLK           in   1        clock, rising edge
//  RST           in   1        asynchronous, active-high reset
//  OP_VALID      in   1        op request from control unit
//  OP_READY      out  1        controller can accept an op (high only in IDLE)
//  OP_CODE       in   3        0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 SP_LD, 6-7 treated as NOP
//  SP_LD_VAL     in   ADDR_W   new SP for SP_LD
//  SCR_ADDR      out  ADDR_W   SCR address
//  SCR_WE        out  1        SCR write enable
//  SCR_DATA_SEL  out  1        data-mux select: 0 register, 1 PC
//  SCR_DOUT      in   DATA_W   SCR read data, valid 1 cycle after address (synchronous read)
//  RESULT_VALID  out  1        1-cycle pulse: RESULT_DATA holds popped word
//  RESULT_DATA   out  DATA_W   popped word, held until next pop/ret result
//  RESULT_IS_PC  out  1        1 when result is from RET, 0 from POP
//  SP            out  ADDR_W   current stack pointer
//  OVF / UNF     out  1        sticky overflow / underflow flags
//  ERR_CLR       in   1        clears OVF and UNF
// BEHAVIOUR
//  Reset (async): state IDLE, SP=SP_RESET, OCC=0, OP_READY=1, SCR_WE=0, SCR_DATA_SEL=0, RESULT_VALID=0,
//   RESULT_DATA=0, RESULT_IS_PC=0, OVF=UNF=0. Reset mid-op aborts: no write, no result, no SP change committed.
//  Handshake: op accepted on a rising edge with OP_VALID & OP_READY. OP_CODE/SP_LD_VAL sampled only then.
//  States: IDLE, WRITE, READ, RESP. In IDLE: SCR_ADDR=SP, SCR_WE=0.
//   PUSH/CALL, OCC<2**ADDR_W: IDLE->WRITE. WRITE (1 cycle): SCR_ADDR=SP-1, SCR_WE=1, SCR_DATA_SEL=1 for CALL
//    else 0. End of WRITE: SP<=SP-1, OCC<=OCC+1 -> IDLE. Latency: 2 cycles accept-to-ready.
//   POP/RET, OCC>0: IDLE->READ. READ: SCR_ADDR=SP, SCR_WE=0 -> RESP. RESP: RESULT_DATA<=SCR_DOUT,
//    RESULT_IS_PC<=(op==RET), RESULT_VALID=1 on cycle after RESP, SP<=SP+1, OCC<=OCC-1 -> IDLE.
//   SP_LD: SP<=SP_LD_VAL, OCC<=0 on accept edge; stays IDLE. NOP/6/7: accepted, no effect.
//  Boundaries:
//   PUSH/CALL with OCC==2**ADDR_W: no write, SP/OCC unchanged, OVF<=1, stays IDLE.
//   POP/RET with OCC==0: no read result, RESULT_VALID stays 0, UNF<=1, stays IDLE.
//   SP arithmetic modulo 2**ADDR_W: PUSH at SP=0 writes address 2**ADDR_W-1; POP at SP=max wraps to 0.
//   ERR_CLR same cycle as a new error: set wins. OCC is ADDR_W+1 bits (0..2**ADDR_W).
//   OP_VALID held high while not ready: no effect; the op is taken when OP_READY returns.
// STRUCTURE
//  Package scr_stack_pkg: op_t enum (OP_NOP..OP_SP_LD), state_t enum, ADDR_W/DATA_W/REG_W defaults.
//  Sub-module scr_sp_reg: SP + OCC registers with dec/inc/load controls and full/empty outputs.
//  Top: FSM, output decode (SCR_* combinational from state/SP), result and flag registers.
// TESTING
//  1 Reset, PUSH REG=8'hA5 -> WRITE cycle addr 8'hFF, WE=1, SEL=0; SP=8'hFF, OP_READY back after 2 cycles.
//  2 CALL PC=10'h2C3 then RET -> write addr SP-1, SEL=1; RESULT_DATA=10'h2C3, RESULT_IS_PC=1, SP restored.
//  3 POP after reset (OCC=0) -> UNF=1, no RESULT_VALID, SP=8'h00; ERR_CLR -> UNF=0.
//  4 SP_LD 8'h10, push 256 words, 257th PUSH -> OVF=1, no WE, SP=8'h10; POPs return words LIFO.
//  5 ERR_CLR asserted in the same cycle as an overflowing PUSH -> OVF=1.
//  6 RST asserted during WRITE -> SCR_WE drops immediately, SP=SP_RESET, OCC=0, OP_READY=1.

Source files
------------

// File: rtl/scr_stack_pkg.sv
// Shared types and default widths for the scratch-RAM stack controller.
// The helper builds the SCR word that the data mux produces for a register push.
package scr_stack_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 10;
  localparam int REG_W_DEF  = 8;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_SP_LD = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [DATA_W_DEF-1:0] zext_reg(input logic [REG_W_DEF-1:0] r);
    return {{(DATA_W_DEF-REG_W_DEF){1'b0}}, r};
  endfunction

endpackage

// File: rtl/scr_sp_reg.sv
// Stack pointer and occupancy registers for the SCR stack.
// The stack grows downward; occupancy is one bit wider so a completely full stack is distinguishable.
module scr_sp_reg #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  SP_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dec,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   OCC_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W:0]   r_occ;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp  <= SP_RESET;
      r_occ <= '0;
    end else if (i_load) begin
      r_sp  <= i_load_val;
      r_occ <= '0;
    end else if (i_dec) begin
      r_sp  <= r_sp - SP_ONE;
      r_occ <= r_occ + OCC_ONE;
    end else if (i_inc) begin
      r_sp  <= r_sp + SP_ONE;
      r_occ <= r_occ - OCC_ONE;
    end
  end

  assign o_sp    = r_sp;
  assign o_full  = r_occ[ADDR_W];
  assign o_empty = (r_occ == '0);

endmodule

// File: rtl/scr_stack_ctrl.sv
// Sequences SCR accesses for PUSH/POP/CALL/RET and owns SP, occupancy and error flags.
// SCR address/strobe are decoded from state and SP; results and flags are registered.
module scr_stack_ctrl
  import scr_stack_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] SP_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [2:0]        i_op_code,
  input  logic [ADDR_W-1:0] i_sp_ld_val,
  output logic [ADDR_W-1:0] o_scr_addr,
  output logic              o_scr_we,
  output logic              o_scr_data_sel,
  input  logic [DATA_W-1:0] i_scr_dout,
  output logic              o_result_valid,
  output logic [DATA_W-1:0] o_result_data,
  output logic              o_result_is_pc,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_ovf,
  output logic              o_unf,
  input  logic              i_err_clr
);

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  state_t            r_state;
  logic              r_is_pc;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_result_data;
  logic              r_result_is_pc;
  logic              r_ovf;
  logic              r_unf;

  op_t               w_op;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_sp;

  assign w_op     = op_t'(i_op_code);
  assign w_accept = i_op_valid && (r_state == ST_IDLE);
  assign w_push   = (w_op == OP_PUSH) || (w_op == OP_CALL);
  assign w_pop    = (w_op == OP_POP)  || (w_op == OP_RET);

  scr_sp_reg #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dec      (r_state == ST_WRITE),
    .i_inc      (r_state == ST_RESP),
    .i_load     (w_accept && (w_op == OP_SP_LD)),
    .i_load_val (i_sp_ld_val),
    .o_sp       (w_sp),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // r_is_pc remembers CALL/RET so WRITE picks the PC mux leg and RESP tags the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_is_pc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_push && !w_full) begin
            r_state <= ST_WRITE;
            r_is_pc <= (w_op == OP_CALL);
          end else if (w_accept && w_pop && !w_empty) begin
            r_state <= ST_READ;
            r_is_pc <= (w_op == OP_RET);
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        ST_READ:  r_state <= ST_RESP;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_result_is_pc <= 1'b0;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      r_result_valid <= (r_state == ST_RESP);
      if (r_state == ST_RESP) begin
        r_result_data  <= i_scr_dout;
        r_result_is_pc <= r_is_pc;
      end
      if (w_accept && w_push && w_full)
        r_ovf <= 1'b1;
      else if (i_err_clr)
        r_ovf <= 1'b0;
      if (w_accept && w_pop && w_empty)
        r_unf <= 1'b1;
      else if (i_err_clr)
        r_unf <= 1'b0;
    end
  end

  assign o_op_ready     = (r_state == ST_IDLE);
  assign o_scr_we       = (r_state == ST_WRITE);
  assign o_scr_addr     = (r_state == ST_WRITE) ? (w_sp - SP_ONE) : w_sp;
  assign o_scr_data_sel = (r_state == ST_WRITE) && r_is_pc;
  assign o_result_valid = r_result_valid;
  assign o_result_data  = r_result_data;
  assign o_result_is_pc = r_result_is_pc;
  assign o_sp           = w_sp;
  assign o_ovf          = r_ovf;
  assign o_unf          = r_unf;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Bench for scr_stack_ctrl: behavioural SCR RAM plus a queue-based stack model.
// Directed scenarios followed by randomized op sequences.
module tb_scr_stack_ctrl;
  import scr_stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_op_valid = 1'b0;
  logic [2:0] i_op_code = 3'd0;
  logic [7:0] i_sp_ld_val = 8'd0;
  logic       i_err_clr = 1'b0;
  logic [9:0] i_scr_dout;

  logic       o_op_ready;
  logic [7:0] o_scr_addr;
  logic       o_scr_we;
  logic       o_scr_data_sel;
  logic       o_result_valid;
  logic [9:0] o_result_data;
  logic       o_result_is_pc;
  logic [7:0] o_sp;
  logic       o_ovf;
  logic       o_unf;

  logic [7:0] tb_reg = 8'd0;
  logic [9:0] tb_pc = 10'd0;
  logic [9:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [9:0] m_q [$];
  logic [7:0] m_sp = 8'd0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [9:0] m_res = 10'd0;
  logic       m_is_pc = 1'b0;

  always #5 clk = ~clk;

  scr_stack_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_op_valid     (i_op_valid),
    .o_op_ready     (o_op_ready),
    .i_op_code      (i_op_code),
    .i_sp_ld_val    (i_sp_ld_val),
    .o_scr_addr     (o_scr_addr),
    .o_scr_we       (o_scr_we),
    .o_scr_data_sel (o_scr_data_sel),
    .i_scr_dout     (i_scr_dout),
    .o_result_valid (o_result_valid),
    .o_result_data  (o_result_data),
    .o_result_is_pc (o_result_is_pc),
    .o_sp           (o_sp),
    .o_ovf          (o_ovf),
    .o_unf          (o_unf),
    .i_err_clr      (i_err_clr)
  );

  always @(posedge clk) begin
    if (o_scr_we) mem[o_scr_addr] <= o_scr_data_sel ? tb_pc : zext_reg(tb_reg);
    i_scr_dout <= mem[o_scr_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("sp", {24'd0, o_sp}, {24'd0, m_sp});
    chk("ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
    chk("unf", {31'd0, o_unf}, {31'd0, m_unf});
    chk("res_data", {22'd0, o_result_data}, {22'd0, m_res});
    chk("res_is_pc", {31'd0, o_result_is_pc}, {31'd0, m_is_pc});
    chk("ready_end", {31'd0, o_op_ready}, 32'd1);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic exec_op(input logic [2:0] op, input logic [7:0] ldv, input logic [7:0] rv,
                         input logic [9:0] pcv, input logic clr);
    tb_reg = rv;
    tb_pc = pcv;
    i_op_code = op;
    i_sp_ld_val = ldv;
    i_err_clr = clr;
    i_op_valid = 1'b1;
    chk("ready_idle", {31'd0, o_op_ready}, 32'd1);
    chk("addr_idle", {24'd0, o_scr_addr}, {24'd0, m_sp});
    @(posedge clk);
    @(negedge clk);
    i_op_valid = 1'b0;
    i_err_clr = 1'b0;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    case (op)
      3'd1, 3'd3: begin
        if (m_q.size() == 256) begin
          m_ovf = 1'b1;
          chk("ovf_no_we", {31'd0, o_scr_we}, 32'd0);
        end else begin
          chk("wr_we", {31'd0, o_scr_we}, 32'd1);
          chk("wr_addr", {24'd0, o_scr_addr}, {24'd0, 8'(m_sp - 8'd1)});
          chk("wr_sel", {31'd0, o_scr_data_sel}, (op == 3'd3) ? 32'd1 : 32'd0);
          chk("wr_busy", {31'd0, o_op_ready}, 32'd0);
          m_q.push_front((op == 3'd3) ? pcv : {2'b00, rv});
          m_sp = m_sp - 8'd1;
          @(negedge clk);
        end
      end
      3'd2, 3'd4: begin
        if (m_q.size() == 0) begin
          m_unf = 1'b1;
          chk("unf_no_rv0", {31'd0, o_result_valid}, 32'd0);
          @(negedge clk);
          chk("unf_no_rv1", {31'd0, o_result_valid}, 32'd0);
        end else begin
          chk("rd_we", {31'd0, o_scr_we}, 32'd0);
          chk("rd_addr", {24'd0, o_scr_addr}, {24'd0, m_sp});
          chk("rd_busy", {31'd0, o_op_ready}, 32'd0);
          @(negedge clk);
          chk("resp_busy", {31'd0, o_op_ready}, 32'd0);
          chk("resp_no_rv", {31'd0, o_result_valid}, 32'd0);
          @(negedge clk);
          m_res = m_q.pop_front();
          m_is_pc = (op == 3'd4);
          m_sp = m_sp + 8'd1;
          chk("res_valid", {31'd0, o_result_valid}, 32'd1);
          chk_state();
          @(negedge clk);
          chk("res_pulse", {31'd0, o_result_valid}, 32'd0);
        end
      end
      3'd5: begin
        m_sp = ldv;
        m_q.delete();
      end
      default: ;
    endcase
    chk_state();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, o_op_ready}, 32'd1);
    chk("rst_we", {31'd0, o_scr_we}, 32'd0);
    chk("rst_sel", {31'd0, o_scr_data_sel}, 32'd0);
    chk("rst_rv", {31'd0, o_result_valid}, 32'd0);
    chk("rst_addr", {24'd0, o_scr_addr}, 32'd0);
    chk_state();
    rst = 1'b0;
    @(negedge clk);

    // PUSH at SP=0 wraps to 0xFF; CALL/RET; POP at SP=0xFF wraps back to 0
    exec_op(3'd1, 8'd0, 8'hA5, 10'h155, 1'b0);
    chk("push_sp_ff", {24'd0, o_sp}, 32'hFF);
    exec_op(3'd3, 8'd0, 8'h11, 10'h2C3, 1'b0);
    exec_op(3'd4, 8'd0, 8'h22, 10'h000, 1'b0);
    chk("ret_data", {22'd0, o_result_data}, 32'h2C3);
    chk("ret_is_pc", {31'd0, o_result_is_pc}, 32'd1);
    exec_op(3'd2, 8'd0, 8'h00, 10'h000, 1'b0);
    chk("pop_data", {22'd0, o_result_data}, 32'h0A5);
    chk("pop_sp_wrap", {24'd0, o_sp}, 32'h00);

    // underflow and clear
    exec_op(3'd2, 8'd0, 8'h00, 10'h000, 1'b0);
    chk("unf_set", {31'd0, o_unf}, 32'd1);
    exec_op(3'd0, 8'd0, 8'h00, 10'h000, 1'b1);
    chk("unf_clr", {31'd0, o_unf}, 32'd0);

    // fill from SP=0x10, overflow, drain LIFO
    exec_op(3'd5, 8'h10, 8'h00, 10'h000, 1'b0);
    for (int i = 0; i < 256; i++)
      exec_op($urandom_range(0, 1) ? 3'd3 : 3'd1, 8'd0, 8'($urandom), 10'($urandom), 1'b0);
    exec_op(3'd1, 8'd0, 8'h5A, 10'h000, 1'b0);
    chk("ovf_set", {31'd0, o_ovf}, 32'd1);
    chk("ovf_sp", {24'd0, o_sp}, 32'h10);
    for (int i = 0; i < 256; i++)
      exec_op($urandom_range(0, 1) ? 3'd4 : 3'd2, 8'd0, 8'd0, 10'd0, 1'b0);

    // refill, clear OVF, then overflow together with ERR_CLR: set wins
    for (int i = 0; i < 256; i++)
      exec_op(3'd1, 8'd0, 8'($urandom), 10'($urandom), 1'b0);
    exec_op(3'd0, 8'd0, 8'd0, 10'd0, 1'b1);
    chk("ovf_clr", {31'd0, o_ovf}, 32'd0);
    exec_op(3'd3, 8'd0, 8'd0, 10'h3FF, 1'b1);
    chk("ovf_set_wins", {31'd0, o_ovf}, 32'd1);
    exec_op(3'd5, 8'h40, 8'd0, 10'd0, 1'b1);

    // OP_VALID held through WRITE must not start a second push
    tb_reg = 8'h77;
    i_op_code = 3'd1;
    i_op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_we", {31'd0, o_scr_we}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_op_valid = 1'b0;
    m_q.push_front(10'h077);
    m_sp = m_sp - 8'd1;
    chk("hold_we_off", {31'd0, o_scr_we}, 32'd0);
    chk_state();
    exec_op(3'd2, 8'd0, 8'd0, 10'd0, 1'b0);
    chk("hold_pop", {22'd0, o_result_data}, 32'h077);

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5 && $urandom_range(0, 3) != 0) op = 3'd1;
      exec_op(op, 8'($urandom), 8'($urandom), 10'($urandom), ($urandom_range(0, 7) == 0));
    end

    // reset during WRITE aborts the push
    if (m_q.size() == 256) exec_op(3'd5, 8'h20, 8'd0, 10'd0, 1'b0);
    tb_reg = 8'h3C;
    i_op_code = 3'd1;
    i_op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_op_valid = 1'b0;
    chk("rstw_we_pre", {31'd0, o_scr_we}, 32'd1);
    rst = 1'b1;
    #1;
    m_q.delete();
    m_sp = 8'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_res = 10'd0;
    m_is_pc = 1'b0;
    chk("rstw_we", {31'd0, o_scr_we}, 32'd0);
    chk("rstw_rv", {31'd0, o_result_valid}, 32'd0);
    chk_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exec_op(3'd2, 8'd0, 8'd0, 10'd0, 1'b0);
    chk("rstw_unf", {31'd0, o_unf}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
